// File: rtl/wm_cycle_ctrl_if.sv
// Front-panel/sensor to sequencer bundle for the washing-machine controller.
// master = panel/sensor side, slave = wm_cycle_ctrl.
interface wm_cycle_ctrl_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic       door_closed;
    logic       level_full;
    logic       level_empty;
    logic       door_lock;
    logic       fill_valve;
    logic       drain_pump;
    logic       wash;
    logic       rinse;
    logic       spin;
    logic       done;
    logic       fault;
    logic [3:0] phase;

    modport master (
        output start, pause, abort, door_closed, level_full, level_empty,
        input  door_lock, fill_valve, drain_pump, wash, rinse, spin, done, fault, phase
    );
    modport slave (
        input  start, pause, abort, door_closed, level_full, level_empty,
        output door_lock, fill_valve, drain_pump, wash, rinse, spin, done, fault, phase
    );
endinterface

// File: rtl/wm_cycle_ctrl.sv
// Washing-machine programme sequencer: fill/wash/drain/fill/rinse/drain/spin
// with door interlock, pause, abort and level-sensor timeout faults.
module wm_cycle_ctrl #(
    parameter int CW      = 8,
    parameter int WASH_T  = 20,
    parameter int RINSE_T = 10,
    parameter int SPIN_T  = 15,
    parameter int LVL_TMO = 30
) (
    input  logic          clk,
    input  logic          reset,
    wm_cycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL1  = 4'd1,
        S_WASH   = 4'd2,
        S_DRAIN1 = 4'd3,
        S_FILL2  = 4'd4,
        S_RINSE  = 4'd5,
        S_DRAIN2 = 4'd6,
        S_SPIN   = 4'd7,
        S_FAULT  = 4'd8
    } state_t;

    localparam logic [CW-1:0] WASH_END  = CW'(WASH_T - 1);
    localparam logic [CW-1:0] RINSE_END = CW'(RINSE_T - 1);
    localparam logic [CW-1:0] SPIN_END  = CW'(SPIN_T - 1);
    localparam logic [CW-1:0] TMO_END   = CW'(LVL_TMO - 1);

    state_t        state, state_n;
    logic [CW-1:0] timer, timer_n;
    logic          paused_q, paused_n;
    logic          done_q, done_n;
    logic          running;

    assign running = (state != S_IDLE) && (state != S_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            paused_q <= paused_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer + CW'(1);
        paused_n = 1'b0;
        done_n   = 1'b0;
        case (state)
            S_IDLE:  if (bus.start && bus.door_closed) state_n = S_FILL1;
            S_FAULT: if (bus.abort) state_n = S_IDLE;
            default: begin
                if (!bus.door_closed) begin
                    state_n = S_FAULT;
                end else if (bus.abort) begin
                    state_n = S_IDLE;
                end else if (bus.pause) begin
                    paused_n = 1'b1;
                    timer_n  = timer;
                end else begin
                    // Sensor arriving on the timeout edge takes precedence over the fault.
                    case (state)
                        S_FILL1:  if (bus.level_full)       state_n = S_WASH;
                                  else if (timer == TMO_END) state_n = S_FAULT;
                        S_WASH:   if (timer == WASH_END)     state_n = S_DRAIN1;
                        S_DRAIN1: if (bus.level_empty)      state_n = S_FILL2;
                                  else if (timer == TMO_END) state_n = S_FAULT;
                        S_FILL2:  if (bus.level_full)       state_n = S_RINSE;
                                  else if (timer == TMO_END) state_n = S_FAULT;
                        S_RINSE:  if (timer == RINSE_END)    state_n = S_DRAIN2;
                        S_DRAIN2: if (bus.level_empty)      state_n = S_SPIN;
                                  else if (timer == TMO_END) state_n = S_FAULT;
                        S_SPIN:   if (timer == SPIN_END) begin
                                      state_n = S_IDLE;
                                      done_n  = 1'b1;
                                  end
                        default:  state_n = S_IDLE;
                    endcase
                end
            end
        endcase
        if (state_n != state || !running) timer_n = '0;
    end

    assign bus.phase      = state;
    assign bus.fault      = (state == S_FAULT);
    assign bus.door_lock  = running;
    assign bus.done       = done_q;
    assign bus.fill_valve = ((state == S_FILL1) || (state == S_FILL2)) && !paused_q;
    assign bus.wash       = (state == S_WASH) && !paused_q;
    assign bus.rinse      = (state == S_RINSE) && !paused_q;
    assign bus.drain_pump = ((state == S_DRAIN1) || (state == S_DRAIN2) || (state == S_SPIN)) && !paused_q;
    assign bus.spin       = (state == S_SPIN) && !paused_q;
endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Self-checking bench for wm_cycle_ctrl: directed programme scenarios plus
// randomized inputs, all compared each cycle against a programme-level model.
module tb_wm_cycle_ctrl;
    localparam int CW = 8, WASH_T = 4, RINSE_T = 3, SPIN_T = 2, LVL_TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wm_cycle_ctrl_if ifc();

    wm_cycle_ctrl #(.CW(CW), .WASH_T(WASH_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T), .LVL_TMO(LVL_TMO)) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Programme-level model: current step, active cycles completed in it, paused flag, done.
    int m_ph = 0, m_el = 0;
    bit m_pz = 1'b0, m_done = 1'b0, m_dn;

    function automatic int step_len(input int ph);
        case (ph)
            2: return WASH_T;
            5: return RINSE_T;
            7: return SPIN_T;
            default: return LVL_TMO;
        endcase
    endfunction

    always @(posedge clk) begin
        m_dn = 1'b0;
        if (reset) begin
            m_ph = 0; m_el = 0; m_pz = 0;
        end else if (m_ph == 0) begin
            m_pz = 0;
            if (ifc.start && ifc.door_closed) begin m_ph = 1; m_el = 0; end
        end else if (m_ph == 8) begin
            if (ifc.abort) m_ph = 0;
        end else if (!ifc.door_closed) begin
            m_ph = 8; m_pz = 0;
        end else if (ifc.abort) begin
            m_ph = 0; m_pz = 0;
        end else if (ifc.pause) begin
            m_pz = 1;
        end else begin
            m_pz = 0;
            m_el++;
            if ((m_ph == 1 || m_ph == 4) && ifc.level_full) begin m_ph++; m_el = 0; end
            else if ((m_ph == 3 || m_ph == 6) && ifc.level_empty) begin m_ph++; m_el = 0; end
            else if (m_el >= step_len(m_ph)) begin
                if (m_ph == 1 || m_ph == 3 || m_ph == 4 || m_ph == 6) m_ph = 8;
                else if (m_ph == 7) begin m_ph = 0; m_dn = 1'b1; end
                else m_ph++;
                m_el = 0;
            end
        end
        m_done = m_dn;
    end

    function automatic logic [12:0] model_vec();
        bit run = (m_ph >= 1 && m_ph <= 7);
        bit act = !m_pz;
        return {4'(m_ph), run,
                act && (m_ph == 1 || m_ph == 4),
                act && (m_ph == 3 || m_ph == 6 || m_ph == 7),
                act && (m_ph == 2), act && (m_ph == 5), act && (m_ph == 7),
                m_done, (m_ph == 8)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {ifc.phase, ifc.door_lock, ifc.fill_valve, ifc.drain_pump,
                ifc.wash, ifc.rinse, ifc.spin, ifc.done, ifc.fault};
    endfunction

    always @(negedge clk) if (chk_en) check("outputs_vs_model", 32'(dut_vec()), 32'(model_vec()));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drum stimulus: full 2 cycles into a fill, empty 1 cycle into a drain.
    int pc = 0, ndone = 0, wash_lo = 0;
    int hist[16];
    logic [3:0] lastp = 4'd0;
    int seq[$];

    task automatic clr_hist();
        for (int i = 0; i < 16; i++) hist[i] = 0;
        seq.delete(); ndone = 0; wash_lo = 0; pc = 0; lastp = ifc.phase;
    endtask

    task automatic auto_step();
        if (ifc.phase != lastp) begin pc = 0; lastp = ifc.phase; end
        ifc.level_full  = (ifc.phase == 4'd1 || ifc.phase == 4'd4) && pc >= 2;
        ifc.level_empty = (ifc.phase == 4'd3 || ifc.phase == 4'd6) && pc >= 1;
        tick(); pc++;
        hist[ifc.phase]++;
        if (ifc.phase == 4'd2 && !ifc.wash) wash_lo++;
        if (ifc.done) ndone++;
        if (seq.size() == 0 || seq[$] != int'(ifc.phase)) seq.push_back(int'(ifc.phase));
    endtask

    task automatic run_until(input logic [3:0] p, input int max);
        int n = 0;
        while (ifc.phase != p && n < max) begin auto_step(); n++; end
        check("reach_phase", 32'(ifc.phase), 32'(p));
    endtask

    task automatic kick();
        ifc.start = 1'b1; auto_step(); ifc.start = 1'b0;
    endtask

    int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};

    initial begin
        ifc.start = 0; ifc.pause = 0; ifc.abort = 0; ifc.door_closed = 1;
        ifc.level_full = 0; ifc.level_empty = 0;
        tick(); chk_en = 1'b1;
        tick(); tick();
        check("reset_state", 32'(dut_vec()), 32'd0);
        reset = 1'b0;
        tick();

        // Full programme
        clr_hist();
        kick();
        check("start_phase1", 32'({ifc.phase, ifc.fill_valve}), 32'({4'd1, 1'b1}));
        run_until(4'd0, 60);
        check("seq_len", 32'(seq.size()), 32'd8);
        for (int i = 0; i < 8 && i < seq.size(); i++) check("seq_phase", 32'(seq[i]), 32'(exp_seq[i]));
        check("wash_len", 32'(hist[2]), 32'd4);
        check("rinse_len", 32'(hist[5]), 32'd3);
        check("spin_len", 32'(hist[7]), 32'd2);
        check("done_seen", 32'(ndone), 32'd1);
        tick();
        check("done_drop", 32'(ifc.done), 32'd0);

        // Start with door open is ignored
        ifc.door_closed = 0; ifc.start = 1;
        repeat (3) tick();
        check("door_open_start", 32'(dut_vec()), 32'd0);
        ifc.door_closed = 1;
        tick();
        ifc.start = 0;
        check("door_closed_start", 32'(ifc.phase), 32'd1);

        // FILL1 timeout
        ifc.level_full = 0;
        repeat (7) tick();
        check("fill_pre_tmo", 32'(ifc.phase), 32'd1);
        tick();
        check("fill_tmo", 32'({ifc.phase, ifc.fault, ifc.door_lock, ifc.fill_valve}), 32'({4'd8, 3'b100}));
        ifc.start = 1; tick(); ifc.start = 0;
        check("fault_ign_start", 32'(ifc.phase), 32'd8);
        ifc.abort = 1; tick(); ifc.abort = 0;
        check("fault_abort", 32'({ifc.phase, ifc.done}), 32'd0);

        // Pause mid-WASH
        clr_hist();
        kick();
        run_until(4'd2, 20);
        auto_step();
        ifc.pause = 1;
        repeat (3) auto_step();
        ifc.pause = 0;
        check("pause_lock", 32'({ifc.door_lock, ifc.wash}), 32'b10);
        run_until(4'd3, 20);
        check("pause_wash_len", 32'(hist[2]), 32'd7);
        check("pause_wash_lo", 32'(wash_lo), 32'd3);
        run_until(4'd0, 60);

        // Door drop in SPIN
        clr_hist();
        kick();
        run_until(4'd7, 60);
        ifc.door_closed = 0;
        auto_step();
        check("door_drop_spin", 32'({ifc.phase, ifc.spin, ifc.drain_pump, ifc.door_lock}), 32'({4'd8, 3'b000}));
        auto_step();
        check("door_drop_nodone", 32'(ndone), 32'd0);
        ifc.door_closed = 1; ifc.abort = 1; tick(); ifc.abort = 0;

        // Abort in RINSE
        kick();
        run_until(4'd5, 60);
        ifc.abort = 1; tick(); ifc.abort = 0;
        check("abort_rinse", 32'({ifc.phase, ifc.done}), 32'd0);
        tick();
        check("abort_nodone", 32'(ifc.done), 32'd0);

        // Reset in RINSE
        kick();
        run_until(4'd5, 60);
        auto_step();
        reset = 1; tick(); reset = 0;
        check("reset_rinse", 32'(dut_vec()), 32'd0);
        tick();

        // Sensor wins over timeout in FILL2
        kick();
        run_until(4'd4, 60);
        ifc.level_full = 0; ifc.level_empty = 0;
        repeat (7) tick();
        check("fill2_pre_tmo", 32'(ifc.phase), 32'd4);
        ifc.level_full = 1; tick(); ifc.level_full = 0;
        check("fill2_sensor_wins", 32'(ifc.phase), 32'd5);
        ifc.abort = 1; tick(); ifc.abort = 0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset           = ($urandom_range(0, 299) == 0);
            ifc.start       = ($urandom_range(0, 2) == 0);
            ifc.pause       = ($urandom_range(0, 9) == 0);
            ifc.abort       = ($urandom_range(0, 39) == 0);
            ifc.door_closed = ($urandom_range(0, 59) != 0);
            ifc.level_full  = ($urandom_range(0, 3) == 0);
            ifc.level_empty = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset = 1; tick(); reset = 0;
        check("final_reset", 32'(dut_vec()), 32'd0);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
